// File: rtl/digitizer_pkg.sv
// Shared register map, bit positions and FSM encoding for the digitizer.
package digitizer_pkg;

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_STATUS   = 4'h4;
    localparam logic [3:0] ADDR_PKT_SIZE = 4'h8;

    localparam int CTRL_START = 0;
    localparam int CTRL_TEST  = 1;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;

    // Each sample occupies one 16-bit half of a stream word.
    localparam int LANE_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/digitizer_packer.sv
// Pairs ADC samples into 32-bit words (first sample low half) behind a
// one-word holding register; flags a pair that finds the register occupied.
module digitizer_packer
    import digitizer_pkg::*;
#(
    parameter int ADC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             deq,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic [31:0]      hold_data,
    output logic             hold_valid,
    output logic             overflow
);

    logic             phase;
    logic [ADC_W-1:0] lo;
    logic             pair_done;
    logic             can_load;

    assign pair_done = en && adc_valid && phase;
    // A word leaving this cycle frees the slot for the pair completing now.
    assign can_load  = !hold_valid || deq;
    assign overflow  = pair_done && !can_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= 1'b0;
            lo         <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (clr) begin
            phase      <= 1'b0;
            lo         <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (en && adc_valid) begin
                phase <= !phase;
                if (!phase) lo <= adc_data;
            end
            if (pair_done && can_load) begin
                hold_data  <= {LANE_W'(adc_data), LANE_W'(lo)};
                hold_valid <= 1'b1;
            end else if (deq) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/digitizer.sv
// Packet digitizer: register file plus IDLE/RUN packet FSM, streaming either
// a word-index test pattern or packed ADC samples over AXI-Stream.
module digitizer
    import digitizer_pkg::*;
#(
    parameter int ADC_W  = 16,
    parameter int SIZE_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       reg_addr,
    input  logic             reg_wr,
    input  logic [31:0]      reg_wdata,
    input  logic             reg_rd,
    output logic [31:0]      reg_rdata,
    output logic             reg_rvalid,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast
);

    state_t            state, state_nxt;
    logic              ctrl_test, mode_test, done, ovf;
    logic [SIZE_W-1:0] pkt_size;
    logic [SIZE_W-3:0] words_left;
    logic [31:0]       tcnt;
    logic              wr_ctrl, start_req, go, go_empty, accept, finish, is_last;
    logic              busy, pk_en, pk_clr, hold_valid, pk_ovf;
    logic [31:0]       hold_data, rd_mux;
    logic              unused_wdata;

    assign unused_wdata = ^reg_wdata;

    assign wr_ctrl   = reg_wr && (reg_addr == ADDR_CTRL);
    assign start_req = wr_ctrl && reg_wdata[CTRL_START] && (state == IDLE);
    assign go        = start_req && (pkt_size[SIZE_W-1:2] != '0);
    assign go_empty  = start_req && (pkt_size[SIZE_W-1:2] == '0);
    assign is_last   = (words_left == (SIZE_W-2)'(1));
    assign accept    = m_tvalid && m_tready;
    assign finish    = accept && is_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go)     state_nxt = RUN;
            RUN:     if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN);
        pk_en    = busy && !mode_test;
        pk_clr   = go || finish;
        m_tvalid = busy && (mode_test || hold_valid);
        m_tlast  = m_tvalid && is_last;
        m_tdata  = '0;
        if (m_tvalid) m_tdata = mode_test ? tcnt : hold_data;
    end

    digitizer_packer #(.ADC_W(ADC_W)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .en         (pk_en),
        .clr        (pk_clr),
        .deq        (accept && !mode_test),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .hold_data  (hold_data),
        .hold_valid (hold_valid),
        .overflow   (pk_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_test  <= 1'b0;
            mode_test  <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            pkt_size   <= '0;
            words_left <= '0;
            tcnt       <= '0;
        end else begin
            if (wr_ctrl) ctrl_test <= reg_wdata[CTRL_TEST];
            if (reg_wr && (reg_addr == ADDR_PKT_SIZE)) pkt_size <= reg_wdata[SIZE_W-1:0];
            // Source is taken from the write that starts the packet.
            if (go) begin
                mode_test  <= reg_wdata[CTRL_TEST];
                words_left <= pkt_size[SIZE_W-1:2];
                tcnt       <= '0;
                done       <= 1'b0;
                ovf        <= 1'b0;
            end else begin
                if (accept) begin
                    words_left <= words_left - 1'b1;
                    tcnt       <= tcnt + 32'd1;
                end
                if (finish || go_empty) done <= 1'b1;
                if (pk_ovf) ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_CTRL:     rd_mux[CTRL_TEST] = ctrl_test;
            ADDR_STATUS: begin
                rd_mux[ST_BUSY] = busy;
                rd_mux[ST_DONE] = done;
                rd_mux[ST_OVF]  = ovf;
            end
            ADDR_PKT_SIZE: rd_mux = 32'(pkt_size);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_rvalid <= 1'b0;
            reg_rdata  <= '0;
        end else begin
            reg_rvalid <= reg_rd;
            reg_rdata  <= reg_rd ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_digitizer.sv
// Scoreboard bench for the digitizer: expected stream words are queued as
// stimulus is applied and popped as the DUT hands words over.
module tb_digitizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  reg_addr;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;

    digitizer #(.ADC_W(16), .SIZE_W(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_addr   (reg_addr),
        .reg_wr     (reg_wr),
        .reg_wdata  (reg_wdata),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          popped = 0;
    logic        rdy_lvl = 1'b1;
    logic        bp_en = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [31:0] held_d = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // tready driver: fixed level, or toggling each cycle for backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        m_tready = bp_en ? !m_tready : rdy_lvl;
    end

    always @(negedge clk) begin
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev && m_tvalid) check("stall_hold", m_tdata, held_d);
            if (m_tvalid && m_tready) begin
                check("sb_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    popped++;
                    check("tdata", m_tdata, e.d);
                    check("tlast", 32'(m_tlast), 32'(e.l));
                end
            end
            stalled_prev = m_tvalid && !m_tready;
            held_d       = m_tdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        tick();
        reg_wr    = 1'b0;
    endtask

    task automatic reg_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        reg_addr = a;
        reg_rd   = 1'b1;
        tick();
        reg_rd   = 1'b0;
        check({tag, "_rvalid"}, 32'(reg_rvalid), 32'd1);
        check(tag, reg_rdata, exp);
    endtask

    task automatic sample(input logic [15:0] d);
        adc_data  = d;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic push_count(input int n);
        for (int i = 0; i < n; i++) sb.push_back({32'(i), (i == n - 1)});
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || m_tvalid) && k < 400) begin
            tick();
            k++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        check("drain_tvalid", 32'(m_tvalid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        reg_addr  = '0;
        reg_wr    = 1'b0;
        reg_wdata = '0;
        reg_rd    = 1'b0;
        adc_data  = '0;
        adc_valid = 1'b0;
        repeat (3) tick();
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_rvalid", 32'(reg_rvalid), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        reset = 1'b0;
        tick();
        reg_check("rst_status", 4'h4, 32'h0);
        reg_check("rst_ctrl", 4'h0, 32'h0);
        reg_check("rst_size", 4'h8, 32'h0);

        // Test pattern, 8 words.
        reg_write(4'h8, 32'h20);
        reg_check("size_rb", 4'h8, 32'h20);
        push_count(8);
        reg_write(4'h0, 32'h3);
        check("first_tvalid", 32'(m_tvalid), 32'd1);
        drain();
        reg_check("test_status", 4'h4, 32'h2);
        reg_check("test_ctrl", 4'h0, 32'h2);
        reg_write(4'h4, 32'hFFFF_FFFF);
        reg_check("status_ro", 4'h4, 32'h2);
        reg_check("unmapped", 4'hC, 32'h0);

        // Same packet under backpressure.
        bp_en = 1'b1;
        push_count(8);
        reg_write(4'h0, 32'h3);
        drain();
        bp_en   = 1'b0;
        rdy_lvl = 1'b1;
        tick();

        // ADC mode; a sample while idle must be discarded.
        sample(16'hAAAA);
        reg_write(4'h8, 32'h8);
        sb.push_back({32'h2222_1111, 1'b0});
        sb.push_back({32'h4444_3333, 1'b1});
        reg_write(4'h0, 32'h1);
        sample(16'h1111);
        sample(16'h2222);
        sample(16'h3333);
        sample(16'h4444);
        drain();
        reg_check("adc_status", 4'h4, 32'h2);

        // Overflow: second pair dropped while the first is stalled.
        rdy_lvl = 1'b0;
        tick();
        reg_write(4'h0, 32'h1);
        sb.push_back({32'h0006_0005, 1'b0});
        sample(16'h0005);
        sample(16'h0006);
        sample(16'h0007);
        sample(16'h0008);
        reg_check("ovf_status", 4'h4, 32'h5);
        rdy_lvl = 1'b1;
        repeat (4) tick();
        check("ovf_first_out", 32'(sb.size()), 32'd0);
        sb.push_back({32'h000A_0009, 1'b1});
        sample(16'h0009);
        sample(16'h000A);
        drain();
        reg_check("ovf_end_status", 4'h4, 32'h6);

        // Reset mid-packet.
        reg_write(4'h8, 32'h20);
        popped = 0;
        push_count(8);
        reg_write(4'h0, 32'h3);
        begin
            int k = 0;
            while (popped < 3 && k < 100) begin
                tick();
                k++;
            end
            check("three_words", 32'(popped), 32'd3);
        end
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_tlast", 32'(m_tlast), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        reg_check("post_rst_status", 4'h4, 32'h0);

        // Zero-length start completes at once.
        reg_write(4'h8, 32'h3);
        reg_write(4'h0, 32'h3);
        check("zero_tvalid", 32'(m_tvalid), 32'd0);
        reg_check("zero_status", 4'h4, 32'h2);

        reg_write(4'h8, 32'h10);
        push_count(4);
        reg_write(4'h0, 32'h3);
        drain();

        // START while busy is ignored.
        reg_write(4'h8, 32'h20);
        push_count(8);
        reg_write(4'h0, 32'h3);
        tick();
        reg_write(4'h0, 32'h3);
        drain();
        repeat (4) tick();
        check("no_restart", 32'(m_tvalid), 32'd0);
        reg_check("busy_start_status", 4'h4, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/digitizer.md
DIGITIZER -- requirements
Module: digitizer

Interface
REQ-001 Parameter ADC_W, default 16, ADC sample width; two samples pack into one 32-bit stream word.
REQ-002 Parameter SIZE_W, default 24, width of the packet-size register in bytes.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 reg_addr  input  4  byte address of register (0x0 CTRL, 0x4 STATUS, 0x8 PKT_SIZE).
REQ-006 reg_wr  input  1  write strobe, one cycle per write.
REQ-007 reg_wdata  input  32  write data.
REQ-008 reg_rd  input  1  read strobe, one cycle per read.
REQ-009 reg_rdata  output  32  read data, valid the cycle after reg_rd.
REQ-010 reg_rvalid  output  1  pulses one cycle after reg_rd.
REQ-011 adc_data  input  ADC_W  ADC sample.
REQ-012 adc_valid  input  1  adc_data valid this cycle.
REQ-013 m_tdata  output  32  AXI-Stream data to DMA.
REQ-014 m_tvalid  output  1  stream valid.
REQ-015 m_tready  input  1  stream ready from DMA.
REQ-016 m_tlast  output  1  last word of packet.

Function
REQ-017 CTRL bit0 START: writing 1 while IDLE starts a packet; it self-clears and reads 0.
REQ-018 CTRL bit1 TEST: 1 selects the test-pattern source, 0 selects the ADC source; it is read/write and is sampled at start.
REQ-019 PKT_SIZE: packet length in bytes; word count = PKT_SIZE>>2, and bits [1:0] are ignored.
REQ-020 STATUS: bit0 BUSY, bit1 DONE (sticky), bit2 OVERFLOW (sticky); it is read-only, and writes are ignored.
REQ-021 Reads of unmapped addresses return 0.
REQ-022 FSM states: IDLE, RUN. On START with word count >= 1, the FSM goes IDLE->RUN, clears DONE and OVERFLOW, and loads the word counter.
REQ-023 On START with word count 0, the FSM stays in IDLE and sets DONE immediately.
REQ-024 START while in RUN is ignored; the TEST bit may still be written and takes effect at the next start.
REQ-025 Test mode: m_tdata = word index, starting at 0 and incrementing by 1 per accepted word; m_tvalid is held high during RUN.
REQ-026 ADC mode: the first sample of a pair goes to [15:0] and the second to [31:16].
REQ-027 ADC mode: a completed pair loads a one-word holding register and raises m_tvalid.
REQ-028 Samples arriving in IDLE are discarded, and the pairing phase resets at start.
REQ-029 OVERFLOW: if a new pair completes while the holding register is still unaccepted, the new pair is dropped, OVERFLOW is set, and the dropped pair does not count toward the packet.
REQ-030 A word is accepted when m_tvalid && m_tready; m_tdata and m_tvalid are held stable until accepted.
REQ-031 m_tlast is high exactly with the final word of the packet.
REQ-032 On acceptance of the last word, the FSM goes RUN->IDLE, BUSY drops and DONE sets in the same edge, and m_tvalid is low next cycle.
REQ-033 Outputs are registered; the first test word appears on m_tvalid one cycle after the START write.

Reset
REQ-034 Reset clears CTRL, STATUS and PKT_SIZE to 0, forces the FSM to IDLE, and clears the counters, the holding register and the pair phase.
REQ-035 During reset, m_tvalid, m_tlast, reg_rvalid, m_tdata and reg_rdata are all 0.
REQ-036 Reset asserted mid-packet aborts the packet with no tlast; after reset, DONE=0.

Structure
REQ-037 A shared package digitizer_pkg holds the register offsets, the CTRL/STATUS bit indices and the state enum typedef.
REQ-038 The register file and FSM stay in the top module.
REQ-039 Sample packing lives in one sub-module, digitizer_packer: ADC sample pairs in, holding register out, with an overflow flag.

Verification
REQ-040 Test mode: PKT_SIZE=0x20, CTRL=0x3 -> 8 words 0..7, tlast on word 7, STATUS=0x2 afterwards.
REQ-041 Backpressure: same packet with m_tready toggled every other cycle -> identical 8 words, data stable while stalled.
REQ-042 ADC mode: PKT_SIZE=0x8, CTRL=0x1, samples 0x1111, 0x2222, 0x3333, 0x4444 -> words 0x22221111, then 0x44443333 with tlast; DONE=1.
REQ-043 Overflow: ADC mode with m_tready=0 and 4 samples -> STATUS bit2=1; the first pair is delivered once ready rises.
REQ-044 Reset mid-packet: assert reset after 3 words -> m_tvalid=0 and STATUS=0; a new start with PKT_SIZE=0x10 produces 4 words 0..3.
REQ-045 Start while busy: write CTRL=0x3 mid-packet -> the packet length is unchanged and no restart occurs.
